// File: rtl/pwl_add2_xfade_ctrl.sv
`timescale 1ns/1ps
// Crossfade sequencer for a two-input PWL adder. It ramps scale1/scale2 between sources in NSTEP steps of DWELL clocks.
// Optional reverse-on-abort feature: define XFADE_ABORT_EN.
module pwl_add2_xfade_ctrl #(
  parameter int NSTEP = 16,
  parameter int DWELL = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
`ifdef XFADE_ABORT_EN
  input  logic                       abort,
  output logic                       aborted,
`endif
  output logic                       busy,
  output logic                       done,
  output logic                       sel,
  output logic [$clog2(NSTEP+1)-1:0] step,
  output logic                       enable,
  output real                        scale1,
  output real                        scale2
);

  localparam int SW = $clog2(NSTEP + 1);
  localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [SW-1:0] K_ZERO = SW'(0);
  localparam logic [SW-1:0] K_ONE  = SW'(1);
  localparam logic [SW-1:0] K_MAX  = SW'(NSTEP);
  localparam logic [DW-1:0] D_ZERO = DW'(0);
  localparam logic [DW-1:0] D_ONE  = DW'(1);
  localparam logic [DW-1:0] D_LAST = DW'(DWELL - 1);

  typedef enum logic [0:0] {IDLE = 1'b0, RAMP = 1'b1} state_t;

  state_t        state;
  logic [DW-1:0] d;
  logic          dir;        // 1: stepping toward NSTEP (in2)
  logic [SW-1:0] tgt;
  logic          abort_flag; // current ramp is a return ramp
  logic [SW-1:0] k_next;
  logic          dwell_end;
  logic          arrive;
`ifdef XFADE_ABORT_EN
  logic [SW-1:0] origin;
  logic          abort_req;
`endif

  function automatic real weight(input logic [SW-1:0] kk);
    return real'(int'(kk)) / real'(NSTEP);
  endfunction

  // Next step index and settle detection for the current ramp
  always_comb begin
    k_next    = dir ? (step + K_ONE) : (step - K_ONE);
    dwell_end = (d == D_LAST);
    arrive    = dwell_end && (k_next == tgt);
`ifdef XFADE_ABORT_EN
    origin    = (tgt == K_MAX) ? K_ZERO : K_MAX;
    abort_req = abort && !abort_flag;
`endif
  end

  // Sequencer FSM with registered handshake, step and weight outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      sel        <= 1'b0;
      step       <= K_ZERO;
      d          <= D_ZERO;
      dir        <= 1'b1;
      tgt        <= K_ZERO;
      abort_flag <= 1'b0;
      scale1     <= 1.0;
      scale2     <= 0.0;
      enable     <= 1'b0;
`ifdef XFADE_ABORT_EN
      aborted    <= 1'b0;
`endif
    end else begin
      enable <= 1'b1;
      done   <= 1'b0;
`ifdef XFADE_ABORT_EN
      aborted <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (start) begin
            state      <= RAMP;
            busy       <= 1'b1;
            d          <= D_ZERO;
            abort_flag <= 1'b0;
            tgt        <= sel ? K_ZERO : K_MAX;
            dir        <= ~sel;
          end
        end
        RAMP: begin
          if (arrive) begin
            // completion beats a coincident abort
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b1;
            step   <= k_next;
            d      <= D_ZERO;
            scale2 <= weight(k_next);
            scale1 <= 1.0 - weight(k_next);
            sel    <= abort_flag ? sel : ~sel;
`ifdef XFADE_ABORT_EN
            aborted <= abort_flag;
`endif
`ifdef XFADE_ABORT_EN
          end else if (abort_req) begin
            abort_flag <= 1'b1;
            d          <= D_ZERO;
            dir        <= ~dir;
            tgt        <= origin;
            if (step == origin) begin
              // nothing to walk back: settle at once
              state   <= IDLE;
              busy    <= 1'b0;
              done    <= 1'b1;
              aborted <= 1'b1;
            end
`endif
          end else if (dwell_end) begin
            d      <= D_ZERO;
            step   <= k_next;
            scale2 <= weight(k_next);
            scale1 <= 1.0 - weight(k_next);
          end else begin
            d <= d + D_ONE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pwl_add2_xfade_ctrl.sv
`timescale 1ns/1ps
// Scoreboard bench for pwl_add2_xfade_ctrl with NSTEP=4, DWELL=2; abort cases run when XFADE_ABORT_EN is defined.
module tb_pwl_add2_xfade_ctrl;

  localparam int NS = 4;
  localparam int DW = 2;

  logic       clk;
  logic       rst;
  logic       start;
  logic       busy;
  logic       done;
  logic       sel;
  logic [2:0] step;
  logic       enable;
  real        scale1;
  real        scale2;
`ifdef XFADE_ABORT_EN
  logic       abort;
  logic       aborted;
`endif

  int n_checks = 0;
  int n_fails  = 0;

  typedef struct {
    string tag;
    int    k;
    real   s2;
    bit    busy;
    bit    done;
    bit    sel;
    bit    ab;
  } exp_t;

  exp_t sb[$];

  pwl_add2_xfade_ctrl #(.NSTEP(NS), .DWELL(DW)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
`ifdef XFADE_ABORT_EN
    .abort  (abort),
    .aborted(aborted),
`endif
    .busy   (busy),
    .done   (done),
    .sel    (sel),
    .step   (step),
    .enable (enable),
    .scale1 (scale1),
    .scale2 (scale2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_real(input string tag, input real obs, input real exp);
    n_checks++;
    assert (obs == exp) else begin
      n_fails++;
      $error("FAIL %s: observed %f expected %f", tag, obs, exp);
    end
  endtask

  task automatic push_one(input string tag, input int k, input bit b, input bit dn,
                          input bit s, input bit ab);
    exp_t e;
    e.tag  = tag;
    e.k    = k;
    e.s2   = real'(k) / real'(NS);
    e.busy = b;
    e.done = dn;
    e.sel  = s;
    e.ab   = ab;
    sb.push_back(e);
  endtask

  // Expected view at edges E0+0 .. E0+n-1 of a ramp launched from source from_sel
  task automatic push_ramp(input string tag, input bit from_sel, input int n);
    for (int t = 0; t < n; t++) begin
      int  k;
      bit  last;
      k    = from_sel ? (NS - t / DW) : (t / DW);
      last = (t == NS * DW);
      push_one($sformatf("%s@%0d", tag, t), k, !last, last, last ? ~from_sel : from_sel, 1'b0);
    end
  endtask

  task automatic run_sb(input bit hold);
    while (sb.size() > 0) begin
      exp_t e;
      tick();
      if (!hold) start = 1'b0;
`ifdef XFADE_ABORT_EN
      abort = 1'b0;
`endif
      e = sb.pop_front();
      chk_int ({e.tag, ".k"},      int'(step), e.k);
      chk_real({e.tag, ".scale2"}, scale2, e.s2);
      chk_real({e.tag, ".scale1"}, scale1, 1.0 - e.s2);
      chk_bit ({e.tag, ".busy"},   busy, e.busy);
      chk_bit ({e.tag, ".done"},   done, e.done);
      chk_bit ({e.tag, ".sel"},    sel, e.sel);
`ifdef XFADE_ABORT_EN
      chk_bit ({e.tag, ".aborted"}, aborted, e.ab);
`endif
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
`ifdef XFADE_ABORT_EN
    abort = 1'b0;
`endif
    // reset held three cycles, start ignored while in reset on the last one
    tick();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_bit ("rst.enable", enable, 1'b0);
    chk_bit ("rst.busy",   busy, 1'b0);
    chk_bit ("rst.done",   done, 1'b0);
    chk_bit ("rst.sel",    sel, 1'b0);
    chk_int ("rst.k",      int'(step), 0);
    chk_real("rst.scale1", scale1, 1.0);
    chk_real("rst.scale2", scale2, 0.0);
    rst = 1'b0;
    tick();
    chk_bit ("rel.enable", enable, 1'b1);
    chk_bit ("rel.busy",   busy, 1'b0);
    chk_real("rel.scale1", scale1, 1.0);

    // full forward ramp from in1 to in2
    start = 1'b1;
    push_ramp("fwd", 1'b0, NS * DW + 1);
    run_sb(1'b0);

    // back-to-back reverse ramp, start held high through the whole ramp
    start = 1'b1;
    push_ramp("b2b", 1'b1, NS * DW + 1);
    run_sb(1'b1);
    start = 1'b0;
    tick();
    chk_bit("b2b.idle.busy", busy, 1'b0);
    chk_bit("b2b.idle.done", done, 1'b0);
    chk_bit("b2b.idle.sel",  sel, 1'b0);
    tick();
    chk_bit("b2b.idle2.busy", busy, 1'b0);
    chk_int("b2b.idle2.k",    int'(step), 0);

    // reset in the middle of a ramp
    start = 1'b1;
    push_ramp("mid", 1'b0, 6);
    run_sb(1'b0);
    rst = 1'b1;
    tick();
    chk_int ("midrst.k",      int'(step), 0);
    chk_real("midrst.scale1", scale1, 1.0);
    chk_real("midrst.scale2", scale2, 0.0);
    chk_bit ("midrst.busy",   busy, 1'b0);
    chk_bit ("midrst.done",   done, 1'b0);
    chk_bit ("midrst.sel",    sel, 1'b0);
    rst = 1'b0;
    tick();
    chk_bit("midrst.done2", done, 1'b0);
    chk_bit("midrst.busy2", busy, 1'b0);

`ifdef XFADE_ABORT_EN
    // abort at E0+5 walks back to in1
    start = 1'b1;
    push_ramp("ab", 1'b0, 5);
    run_sb(1'b0);
    abort = 1'b1;
    push_one("ab@5", 2, 1'b1, 1'b0, 1'b0, 1'b0);
    push_one("ab@6", 2, 1'b1, 1'b0, 1'b0, 1'b0);
    push_one("ab@7", 1, 1'b1, 1'b0, 1'b0, 1'b0);
    push_one("ab@8", 1, 1'b1, 1'b0, 1'b0, 1'b0);
    push_one("ab@9", 0, 1'b0, 1'b1, 1'b0, 1'b1);
    run_sb(1'b0);
    tick();
    chk_bit("ab.after.aborted", aborted, 1'b0);
    chk_bit("ab.after.done",    done, 1'b0);

    // abort coinciding with the completing edge is ignored
    start = 1'b1;
    push_ramp("abl", 1'b0, NS * DW);
    run_sb(1'b0);
    abort = 1'b1;
    push_one("abl@8", NS, 1'b0, 1'b1, 1'b1, 1'b0);
    run_sb(1'b0);
    tick();
    chk_bit("abl.after.sel",  sel, 1'b1);
    chk_bit("abl.after.busy", busy, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/pwl_add2_xfade_ctrl.md
# pwl_add2_xfade_ctrl

Clocked crossfade sequencer for a two-input PWL adder. It owns the adder's `scale1`, `scale2` and `enable` inputs and ramps the weighting from the currently active source to the other one in `NSTEP` equal steps. Each step is held for `DWELL` clocks. A start/busy/done handshake serves the digital control logic that requests a source switch.

## Interface
Parameters:
- `NSTEP`, 16: number of steps per full crossfade; must be ≥ 1.
- `DWELL`, 1: clocks each step is held; must be ≥ 1.

Ports:
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `start`  input  1  request a crossfade to the inactive source; sampled on `clk`.
- `abort`  input  1  reverse an in-flight crossfade. Present only with `XFADE_ABORT_EN`.
- `busy`  output  1  high while a crossfade is in progress.
- `done`  output  1  one-cycle pulse when a crossfade (or aborted crossfade) settles.
- `aborted`  output  1  qualifies `done`: high with `done` when the settle was an abort return. Present only with `XFADE_ABORT_EN`.
- `sel`  output  1  active source at rest: 0 = `in1`, 1 = `in2`.
- `step`  output  $clog2(NSTEP+1)  current step index `k`, range 0..NSTEP.
- `enable`  output  1  drives the adder enable.
- `scale1`  output  real  weight for `in1`.
- `scale2`  output  real  weight for `in2`.

## Operation
- State: FSM {IDLE, RAMP}; step counter `k`; dwell counter `d` (0..DWELL-1); direction `dir` (+1/-1); target `tgt`.
- Weights are registered reals, updated on the same edge as `k`:
  - `scale2 = k / NSTEP` (real division).
  - `scale1 = 1.0 - scale2`.
  - The sum is always exactly 1.0 at step boundaries.
- IDLE:
  - `k` is 0 when `sel=0` and NSTEP when `sel=1`.
  - `start=1` → RAMP, `d=0`, `tgt` = NSTEP if `sel=0` else 0, `dir` toward `tgt`, `busy=1`.
- RAMP, each edge:
  - If `d==DWELL-1`: set `d=0` and `k+=dir`. Otherwise `d++`.
  - When `k` reaches `tgt`, on that same edge:
    - go to IDLE, `busy=0`, `done=1` for one cycle.
    - `sel` toggles, unless the ramp was aborted.
- `start` while RAMP is ignored; there is no queueing.
- `start` in the cycle `done` is high is accepted, giving back-to-back crossfades.
- `enable` is a registered `~rst`: 0 throughout reset, 1 from the first edge with `rst=0`. While `enable=0` the adder holds its output.
- Reset values: IDLE, `busy=0`, `done=0`, `aborted=0`, `sel=0`, `k=0`, `d=0`, `scale1=1.0`, `scale2=0.0`, `enable=0`.
- Reset mid-RAMP: on the next edge all state returns to the reset values. No `done` pulse is produced.
- `rst` and `start` high together: reset wins.

## Timing
- Start accepted at edge E0: `busy` rises at E0.
- First weight change at E0+DWELL.
- Settle at E0+NSTEP·DWELL: `k=tgt`, `busy=0`, `done=1`, `sel` updated, all on this edge.
- Full crossfade latency: NSTEP·DWELL clocks. Weights are piecewise constant between step edges.
- NSTEP=1: a single jump at E0+DWELL.

## Configuration
- `XFADE_ABORT_EN` defined:
  - `abort` and `aborted` ports exist.
  - `abort=1` in RAMP: `dir` negates, `tgt` becomes the origin endpoint, `d` resets to 0, and a latched abort flag is set.
  - The return ramp walks back from the current `k` at the same DWELL rate.
  - On settle: `done=1`, `aborted=1`, `sel` unchanged.
  - Ignored cases:
    - `abort` in IDLE.
    - `abort` on the edge where `k` reaches `tgt` (completion wins).
    - a second `abort` during a return ramp.
- Undefined: no `abort`/`aborted` ports; every started crossfade runs to completion.

## Test plan
- Reset behaviour, NSTEP=4, DWELL=2: hold `rst` 3 cycles, then release → `scale1=1.0`, `scale2=0.0`, `sel=0`, `busy=0`, `enable` 0 in reset and 1 one edge after release.
- Full ramp, NSTEP=4, DWELL=2: `start` pulse at E0 → `scale2` = 0.25/0.5/0.75/1.0 at E0+2/4/6/8. At E0+8: `done` pulse, `busy=0`, `sel=1`.
- Back-to-back: `start` asserted in the `done` cycle → reverse ramp, `scale2` 0.75 at +2 and 0.0 at +8, then `sel=0`. `start` held during RAMP causes no extra ramp.
- Reset mid-ramp: `rst` at E0+5 → next edge `k=0`, `scale1=1.0`, `busy=0`, no `done`.
- With `XFADE_ABORT_EN`, NSTEP=4, DWELL=2: `abort` at E0+5 (`k=2`) → `k`=1 at E0+7, 0 at E0+9. At E0+9: `done=1`, `aborted=1`, `sel=0`.
- With `XFADE_ABORT_EN`: `abort` on the completing edge is ignored, giving `sel=1` and `aborted=0`.
